uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer entries; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge; one clock domain only.
REQ-005 SHALL have port TX_rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port TX_data  input  8  byte to transmit; sampled when TX_valid and TX_ready are both high.
REQ-007 SHALL have port TX_valid  input  1  TX_data holds a byte for the block to accept.
REQ-008 SHALL have port TX_ready  output  1  high when the FIFO is not full.
REQ-009 SHALL have port TX_out  output  1  serial line; idle level is 1.
REQ-010 SHALL have port TX_idle  output  1  high when the FSM is in IDLE and the FIFO is empty.
REQ-011 SHALL have port TX_done  output  1  one-cycle pulse on the last clock of each stop bit.

Function
REQ-012 SHALL use bit period DIV = CLK_FREQ/BAUD_RATE clocks (integer division); the counter width is $clog2(DIV); each bit lasts exactly DIV cycles.
REQ-013 SHALL send frames LSB first: start bit (0), 8 data bits, optional parity bit (REQ-024), one stop bit (1).
REQ-014 SHALL run FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE->START when the FIFO is non-empty; the head entry is popped into the shift register.
- START->DATA after DIV cycles.
- DATA->PARITY or STOP after the 8th bit (3-bit index reaches 7).
- PARITY->STOP after DIV cycles.
- STOP->START directly if the FIFO is non-empty at the end of the stop bit, otherwise STOP->IDLE.
REQ-015 SHALL accept a push iff TX_valid and TX_ready are high on a rising edge; a push while full is impossible (TX_ready=0) and TX_valid is ignored.
REQ-016 SHALL deassert TX_ready when the FIFO is full, even if a pop occurs in the same cycle; a simultaneous push and pop when not full SHALL leave the count unchanged.
REQ-017 SHALL drive the start bit on TX_out starting 1 cycle after the accepting edge when the block is fully idle (push at edge N, TX_out=0 from edge N+1).
REQ-018 SHALL leave no idle gap between back-to-back frames; the next start bit follows the stop bit's last cycle.
REQ-019 SHALL register TX_out, so TX_out is glitch-free.
REQ-020 SHALL let the FIFO read/write pointers wrap modulo FIFO_DEPTH, using an extra MSB to tell full from empty.

Reset
REQ-021 SHALL force, on TX_rst low and independent of clk: TX_out=1, TX_ready=1, TX_idle=1, TX_done=0, FSM=IDLE, FIFO empty, counters 0.
REQ-022 SHALL, on reset mid-frame, abort the frame immediately and discard all buffered bytes; no partial frame resumes.
REQ-023 SHALL treat reset deassertion as synchronous-release safe; the first push can be accepted on the first edge after release.

Configuration
REQ-024 SHALL, with UART_TX_PARITY_EN defined, insert an even-parity bit (XOR of the 8 data bits) between DATA and STOP; a frame is 11 bits.
REQ-025 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and its logic entirely; a frame is 10 bits.

Structure
REQ-026 SHALL place the shared constants in package uart_pkg: FSM state encodings, UART_DATA_BITS=8, idle line level, and the baud divisor function, so the RX side can reuse them.
REQ-027 SHALL implement the buffer as sub-module uart_tx_fifo (push/pop/full/empty, parameter FIFO_DEPTH); the FSM, baud counter and shift register stay in uart_tx.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, DIV=10)
REQ-028 Single byte 0xA5 pushed while idle -> TX_out 0 for 10 clocks from edge N+1, then 1,0,1,0,0,1,0,1 for 10 clocks each, then 1 for 10 clocks; TX_done pulses once; TX_idle returns high.
REQ-029 Push 5 bytes on consecutive cycles with FIFO_DEPTH=4 -> TX_ready low exactly while 4 entries are held; all 5 bytes arrive in order with no gap between stop and start bits.
REQ-030 Assert TX_rst low at clock 35 of a frame with 3 bytes queued -> TX_out=1 immediately; TX_idle=1; after release no further frame appears.
REQ-031 With UART_TX_PARITY_EN, byte 0x07 -> parity bit 1 after bit 7; byte 0x03 -> parity bit 0; frame length 110 clocks.
REQ-032 Push 0x00 at the exact cycle the STOP of the previous frame ends -> next start bit begins without gap; TX_ready remains high throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: state encodings, data width, idle line level, baud divisor.
// ST_PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int uart_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream valid/ready handshake feeding the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] TX_data;
  logic                      TX_valid;
  logic                      TX_ready;

  modport master (output TX_data, output TX_valid, input TX_ready);
  modport slave  (input TX_data, input TX_valid, output TX_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO, FIFO_DEPTH entries (power of two, >= 2); show-ahead head output.
// Pointers carry one extra MSB so full and empty are distinguishable after wrap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      TX_rst,
  input  logic                      i_push,
  input  logic [UART_DATA_BITS-1:0] i_push_dat,
  input  logic                      i_pop,
  output logic [UART_DATA_BITS-1:0] o_head_dat,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [UART_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]               r_wr_ptr;
  logic [AW:0]               r_rd_ptr;

  always_ff @(posedge clk or negedge TX_rst) begin
    if (!TX_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, [even parity if UART_TX_PARITY_EN], stop.
// Bit period CLK_FREQ/BAUD_RATE clocks; TX_out registered; TX_ready low while FIFO full.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     TX_rst,
  uart_tx_if.slave s_if,
  output logic     TX_out,
  output logic     TX_idle,
  output logic     TX_done
);

  localparam int                DIV      = uart_baud_div(CLK_FREQ, BAUD_RATE);
  localparam int                CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [2:0]        BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e               r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [2:0]                r_bit_idx, w_bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                      r_tx, w_tx_nxt;
  logic                      w_push, w_fifo_push, w_pop, w_load, w_bypass;
  logic                      w_full, w_empty, w_bit_end;
  logic [UART_DATA_BITS-1:0] w_head;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity;
`endif

  assign w_push        = s_if.TX_valid && !w_full;
  assign w_fifo_push   = w_push && !w_bypass;
  assign s_if.TX_ready = !w_full;
  assign w_bit_end     = (r_cnt == CNT_LAST);

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .TX_rst     (TX_rst),
    .i_push     (w_fifo_push),
    .i_push_dat (s_if.TX_data),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or negedge TX_rst) begin
    if (!TX_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= UART_IDLE_LEVEL;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge TX_rst) begin
    if (!TX_rst)     r_parity <= 1'b0;
    else if (w_load) r_parity <= ^w_shift_nxt;
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CNT_W'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_pop         = 1'b0;
    w_load        = 1'b0;
    w_bypass      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        w_load    = !w_empty;
      end
      ST_START: if (w_bit_end) begin
        w_state_nxt = ST_DATA;
        w_cnt_nxt   = '0;
        w_tx_nxt    = r_shift[0];
      end
      ST_DATA: if (w_bit_end) begin
        w_cnt_nxt = '0;
        if (r_bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = ST_PARITY;
          w_tx_nxt    = r_parity;
`else
          w_state_nxt = ST_STOP;
          w_tx_nxt    = 1'b1;
`endif
        end else begin
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          w_shift_nxt   = r_shift >> 1;
          w_tx_nxt      = r_shift[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (w_bit_end) begin
        w_state_nxt = ST_STOP;
        w_cnt_nxt   = '0;
        w_tx_nxt    = 1'b1;
      end
`endif
      ST_STOP: if (w_bit_end) begin
        w_cnt_nxt = '0;
        // A byte offered on the very edge the stop bit ends skips the FIFO so no gap appears.
        if (!w_empty) begin
          w_load = 1'b1;
        end else if (s_if.TX_valid) begin
          w_load   = 1'b1;
          w_bypass = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_tx_nxt    = UART_IDLE_LEVEL;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = UART_IDLE_LEVEL;
      end
    endcase
    if (w_load) begin
      w_pop         = !w_bypass;
      w_state_nxt   = ST_START;
      w_cnt_nxt     = '0;
      w_bit_idx_nxt = '0;
      w_shift_nxt   = w_bypass ? s_if.TX_data : w_head;
      w_tx_nxt      = 1'b0;
    end
  end

  assign TX_out  = r_tx;
  assign TX_idle = (r_state == ST_IDLE) && w_empty;
  assign TX_done = (r_state == ST_STOP) && w_bit_end;

endmodule
